// File: rtl/pc_sequencer.sv
// PC-update stage for the Y86 core: next-PC selection, machine status FSM,
// circular return-address stack with mispredict flag, and retire/skip counters.
module pc_sequencer #(
   parameter int unsigned          ADDR_W       = 64,
   parameter int unsigned          RAS_DEPTH    = 8,
   parameter logic [ADDR_W-1:0]    RESET_PC     = {ADDR_W{1'b0}},
   parameter bit                   SKIP_INVALID = 1'b1,
   localparam int unsigned         PTR_W        = $clog2(RAS_DEPTH),
   localparam int unsigned         CNT_W        = $clog2(RAS_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   input  logic              stall,
   input  logic [3:0]        icode,
   input  logic              cnd,
   input  logic [ADDR_W-1:0] valc,
   input  logic [ADDR_W-1:0] valm,
   input  logic [ADDR_W-1:0] valp,
   input  logic              invalid_instr,
   input  logic              mem_error,
   output logic [ADDR_W-1:0] pc,
   output logic [1:0]        stat,
   output logic              running,
   output logic              ras_mispredict,
   output logic [CNT_W-1:0]  ras_count,
   output logic [31:0]       retired,
   output logic [15:0]       skipped
);

   typedef enum logic [1:0] {
      ST_AOK = 2'd0,
      ST_HLT = 2'd1,
      ST_ADR = 2'd2,
      ST_INS = 2'd3
   } state_e;

   localparam logic [3:0]        IC_HALT = 4'h0;
   localparam logic [3:0]        IC_JXX  = 4'h7;
   localparam logic [3:0]        IC_CALL = 4'h8;
   localparam logic [3:0]        IC_RET  = 4'h9;
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RAS_DEPTH);
   localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                running_q, running_d;
   logic                mispredict_q, mispredict_d;
   logic [CNT_W-1:0]    ras_count_q, ras_count_d;
   logic [PTR_W-1:0]    ras_ptr_q, ras_ptr_d;
   logic [31:0]         retired_q, retired_d;
   logic [15:0]         skipped_q, skipped_d;

   logic [ADDR_W-1:0]   ras_mem [RAS_DEPTH];
   logic                ras_wr_en_s;
   logic [PTR_W-1:0]    ras_top_idx_s;
   logic                event_s;

   assign event_s       = instr_valid && !stall && (state_q == ST_AOK);
   assign ras_top_idx_s = ras_ptr_q - PTR_W'(1);

   // Next-state, next-PC, RAS and counter update for one update event
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      mispredict_d = 1'b0;
      ras_count_d  = ras_count_q;
      ras_ptr_d    = ras_ptr_q;
      retired_d    = retired_q;
      skipped_d    = skipped_q;
      ras_wr_en_s  = 1'b0;

      if (event_s) begin
         if (mem_error) begin
            state_d = ST_ADR;
         end else if (invalid_instr) begin
            if (SKIP_INVALID) begin
               pc_d = pc_q + PC_ONE;
               if (skipped_q != 16'hFFFF) begin
                  skipped_d = skipped_q + 16'd1;
               end else begin
                  skipped_d = skipped_q;
               end
            end else begin
               state_d = ST_INS;
            end
         end else if (icode == IC_HALT) begin
            state_d   = ST_HLT;
            retired_d = retired_q + 32'd1;
         end else begin
            retired_d = retired_q + 32'd1;
            case (icode)
               IC_JXX: begin
                  pc_d = cnd ? valc : valp;
               end
               IC_CALL: begin
                  pc_d        = valc;
                  ras_wr_en_s = 1'b1;
                  ras_ptr_d   = ras_ptr_q + PTR_W'(1);
                  // Full stack keeps its count; the write slot already holds the oldest entry
                  if (ras_count_q != CNT_FULL) begin
                     ras_count_d = ras_count_q + CNT_W'(1);
                  end else begin
                     ras_count_d = ras_count_q;
                  end
               end
               IC_RET: begin
                  pc_d = valm;
                  if (ras_count_q == {CNT_W{1'b0}}) begin
                     mispredict_d = 1'b1;
                  end else begin
                     mispredict_d = (ras_mem[ras_top_idx_s] != valm);
                     ras_ptr_d    = ras_top_idx_s;
                     ras_count_d  = ras_count_q - CNT_W'(1);
                  end
               end
               default: begin
                  pc_d = valp;
               end
            endcase
         end
      end else begin
         state_d = state_q;
      end

      running_d = (state_d == ST_AOK);
   end

   // Architectural state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_AOK;
         pc_q         <= RESET_PC;
         running_q    <= 1'b1;
         mispredict_q <= 1'b0;
         ras_count_q  <= {CNT_W{1'b0}};
         ras_ptr_q    <= {PTR_W{1'b0}};
         retired_q    <= 32'd0;
         skipped_q    <= 16'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         running_q    <= running_d;
         mispredict_q <= mispredict_d;
         ras_count_q  <= ras_count_d;
         ras_ptr_q    <= ras_ptr_d;
         retired_q    <= retired_d;
         skipped_q    <= skipped_d;
      end
   end

   // Return-address storage; contents need no reset since ras_count gates reads
   always_ff @(posedge clk) begin
      if (ras_wr_en_s) begin
         ras_mem[ras_ptr_q] <= valp;
      end
   end

   assign pc             = pc_q;
   assign stat           = state_q;
   assign running        = running_q;
   assign ras_mispredict = mispredict_q;
   assign ras_count      = ras_count_q;
   assign retired        = retired_q;
   assign skipped        = skipped_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for the basic flow plus
// hand sequences for RAS wrap, async reset, PC wrap, halt and address error.
module tb_pc_sequencer;

   localparam int ADDR_W = 64;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              instr_valid = 1'b0;
   logic              stall = 1'b0;
   logic [3:0]        icode = 4'h1;
   logic              cnd = 1'b0;
   logic [ADDR_W-1:0] valc = 64'd0;
   logic [ADDR_W-1:0] valm = 64'd0;
   logic [ADDR_W-1:0] valp = 64'd0;
   logic              invalid_instr = 1'b0;
   logic              mem_error = 1'b0;

   logic [ADDR_W-1:0] pc, pc2;
   logic [1:0]        stat, stat2;
   logic              running, running2;
   logic              misp, misp2;
   logic [CNT_W-1:0]  cnt, cnt2;
   logic [31:0]       retired, retired2;
   logic [15:0]       skipped, skipped2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.ADDR_W(ADDR_W), .RAS_DEPTH(8), .RESET_PC(64'd0), .SKIP_INVALID(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .stall(stall), .icode(icode),
      .cnd(cnd), .valc(valc), .valm(valm), .valp(valp), .invalid_instr(invalid_instr),
      .mem_error(mem_error), .pc(pc), .stat(stat), .running(running), .ras_mispredict(misp),
      .ras_count(cnt), .retired(retired), .skipped(skipped));

   pc_sequencer #(.ADDR_W(ADDR_W), .RAS_DEPTH(8), .RESET_PC(64'd0), .SKIP_INVALID(1'b0)) dut_ns (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .stall(stall), .icode(icode),
      .cnd(cnd), .valc(valc), .valm(valm), .valp(valp), .invalid_instr(invalid_instr),
      .mem_error(mem_error), .pc(pc2), .stat(stat2), .running(running2), .ras_mispredict(misp2),
      .ras_count(cnt2), .retired(retired2), .skipped(skipped2));

   typedef struct {
      logic        valid;
      logic        stl;
      logic [3:0]  ic;
      logic        c;
      logic [63:0] vc;
      logic [63:0] vm;
      logic [63:0] vp;
      logic        inv;
      logic [63:0] e_pc;
      logic [1:0]  e_stat;
      logic        e_misp;
      logic [3:0]  e_cnt;
      logic [31:0] e_ret;
      logic [15:0] e_skip;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [63:0] e_pc, input logic [1:0] e_stat,
                          input logic e_misp, input logic [3:0] e_cnt, input logic [31:0] e_ret,
                          input logic [15:0] e_skip);
      chk({tag, ".pc"}, pc, e_pc);
      chk({tag, ".stat"}, {62'd0, stat}, {62'd0, e_stat});
      chk({tag, ".running"}, {63'd0, running}, {63'd0, (e_stat == 2'd0)});
      chk({tag, ".misp"}, {63'd0, misp}, {63'd0, e_misp});
      chk({tag, ".cnt"}, {60'd0, cnt}, {60'd0, e_cnt});
      chk({tag, ".retired"}, {32'd0, retired}, {32'd0, e_ret});
      chk({tag, ".skipped"}, {48'd0, skipped}, {48'd0, e_skip});
   endtask

   task automatic drive(input logic v, input logic s, input logic [3:0] ic, input logic c,
                        input logic [63:0] vc, input logic [63:0] vm, input logic [63:0] vp,
                        input logic inv, input logic me);
      instr_valid   = v;
      stall         = s;
      icode         = ic;
      cnd           = c;
      valc          = vc;
      valm          = vm;
      valp          = vp;
      invalid_instr = inv;
      mem_error     = me;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 4'h1, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      int exp_ret;

      //            valid stl  ic    c     valc        valm    valp     inv   e_pc        st    misp  cnt   ret     skip
      vecs[0]  = '{1'b1, 1'b0, 4'h1, 1'b0, 64'd0,     64'd0,  64'd1,   1'b0, 64'd1,      2'd0, 1'b0, 4'd0, 32'd1,  16'd0};
      vecs[1]  = '{1'b1, 1'b0, 4'h2, 1'b0, 64'd0,     64'd0,  64'd3,   1'b0, 64'd3,      2'd0, 1'b0, 4'd0, 32'd2,  16'd0};
      vecs[2]  = '{1'b1, 1'b0, 4'h3, 1'b0, 64'd0,     64'd0,  64'd13,  1'b0, 64'd13,     2'd0, 1'b0, 4'd0, 32'd3,  16'd0};
      vecs[3]  = '{1'b1, 1'b0, 4'h7, 1'b0, 64'h1110,  64'd0,  64'd24,  1'b0, 64'd24,     2'd0, 1'b0, 4'd0, 32'd4,  16'd0};
      vecs[4]  = '{1'b1, 1'b0, 4'h7, 1'b1, 64'h1110,  64'd0,  64'd24,  1'b0, 64'h1110,   2'd0, 1'b0, 4'd0, 32'd5,  16'd0};
      vecs[5]  = '{1'b1, 1'b0, 4'h8, 1'b0, 64'h100,   64'd0,  64'd33,  1'b0, 64'h100,    2'd0, 1'b0, 4'd1, 32'd6,  16'd0};
      vecs[6]  = '{1'b1, 1'b0, 4'h9, 1'b0, 64'd0,     64'd33, 64'd2,   1'b0, 64'd33,     2'd0, 1'b0, 4'd0, 32'd7,  16'd0};
      vecs[7]  = '{1'b1, 1'b0, 4'h9, 1'b0, 64'd0,     64'd5,  64'd2,   1'b0, 64'd5,      2'd0, 1'b1, 4'd0, 32'd8,  16'd0};
      vecs[8]  = '{1'b1, 1'b0, 4'h1, 1'b0, 64'd0,     64'd0,  64'd6,   1'b0, 64'd6,      2'd0, 1'b0, 4'd0, 32'd9,  16'd0};
      vecs[9]  = '{1'b1, 1'b1, 4'h1, 1'b0, 64'd0,     64'd0,  64'd99,  1'b0, 64'd6,      2'd0, 1'b0, 4'd0, 32'd9,  16'd0};
      vecs[10] = '{1'b0, 1'b0, 4'h1, 1'b0, 64'd0,     64'd0,  64'd99,  1'b0, 64'd6,      2'd0, 1'b0, 4'd0, 32'd9,  16'd0};
      vecs[11] = '{1'b1, 1'b0, 4'h1, 1'b0, 64'd0,     64'd0,  64'd38,  1'b0, 64'd38,     2'd0, 1'b0, 4'd0, 32'd10, 16'd0};
      vecs[12] = '{1'b1, 1'b0, 4'h5, 1'b0, 64'd0,     64'd0,  64'd77,  1'b1, 64'd39,     2'd0, 1'b0, 4'd0, 32'd10, 16'd1};

      // Reset state
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_all("reset", 64'd0, 2'd0, 1'b0, 4'd0, 32'd0, 16'd0);

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].valid, vecs[i].stl, vecs[i].ic, vecs[i].c, vecs[i].vc, vecs[i].vm,
               vecs[i].vp, vecs[i].inv, 1'b0);
         chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_stat, vecs[i].e_misp,
                 vecs[i].e_cnt, vecs[i].e_ret, vecs[i].e_skip);
      end

      // Non-skipping instance froze in INS at the invalid byte
      chk("ns.stat", {62'd0, stat2}, 64'd3);
      chk("ns.pc", pc2, 64'd38);
      chk("ns.running", {63'd0, running2}, 64'd0);
      chk("ns.skipped", {48'd0, skipped2}, 64'd0);
      drive(1'b1, 1'b0, 4'h1, 1'b0, 64'd0, 64'd0, 64'd50, 1'b0, 1'b0);
      chk("ns.frozen_pc", pc2, 64'd38);
      chk("ns.frozen_ret", {32'd0, retired2}, 64'd10);

      // RAS overflow: 9 calls then 9 returns on an 8-deep stack
      do_reset();
      exp_ret = 0;
      for (int k = 1; k <= 9; k++) begin
         drive(1'b1, 1'b0, 4'h8, 1'b0, 64'h200 + 64'(k), 64'd0, 64'(k), 1'b0, 1'b0);
         exp_ret++;
         chk_all($sformatf("call%0d", k), 64'h200 + 64'(k), 2'd0, 1'b0,
                 (k > 8) ? 4'd8 : 4'(k), 32'(exp_ret), 16'd0);
      end
      for (int k = 9; k >= 2; k--) begin
         drive(1'b1, 1'b0, 4'h9, 1'b0, 64'd0, 64'(k), 64'd0, 1'b0, 1'b0);
         exp_ret++;
         chk_all($sformatf("ret%0d", k), 64'(k), 2'd0, 1'b0, 4'(k - 2), 32'(exp_ret), 16'd0);
      end
      drive(1'b1, 1'b0, 4'h9, 1'b0, 64'd0, 64'd1, 64'd0, 1'b0, 1'b0);
      exp_ret++;
      chk_all("ret_empty", 64'd1, 2'd0, 1'b1, 4'd0, 32'(exp_ret), 16'd0);

      // Wrong return target on a non-empty stack
      drive(1'b1, 1'b0, 4'h8, 1'b0, 64'h40, 64'd0, 64'h11, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 4'h9, 1'b0, 64'd0, 64'h12, 64'd0, 1'b0, 1'b0);
      exp_ret += 2;
      chk_all("ret_wrong", 64'h12, 2'd0, 1'b1, 4'd0, 32'(exp_ret), 16'd0);

      // Asynchronous reset between edges with a populated stack
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b0, 4'h8, 1'b0, 64'h100, 64'd0, 64'(k + 1), 1'b0, 1'b0);
      end
      chk("pre_rst.pc", pc, 64'h100);
      chk("pre_rst.cnt", {60'd0, cnt}, 64'd3);
      instr_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 64'd0, 2'd0, 1'b0, 4'd0, 32'd0, 16'd0);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // PC wraps to zero when skipping past all-ones
      drive(1'b1, 1'b0, 4'h1, 1'b0, 64'd0, 64'd0, {64{1'b1}}, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 4'h1, 1'b0, 64'd0, 64'd0, 64'd5, 1'b1, 1'b0);
      chk_all("pc_wrap", 64'd0, 2'd0, 1'b0, 4'd0, 32'd1, 16'd1);

      // Halt is terminal and counts as retired
      drive(1'b1, 1'b0, 4'h1, 1'b0, 64'd0, 64'd0, 64'd4, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 4'h0, 1'b0, 64'd0, 64'd0, 64'd6, 1'b0, 1'b0);
      chk_all("halt", 64'd4, 2'd1, 1'b0, 4'd0, 32'd3, 16'd1);
      drive(1'b1, 1'b0, 4'h9, 1'b0, 64'd0, 64'd9, 64'd8, 1'b0, 1'b0);
      chk_all("halt_hold", 64'd4, 2'd1, 1'b0, 4'd0, 32'd3, 16'd1);

      // mem_error wins over invalid_instr and halt; then everything is ignored
      do_reset();
      drive(1'b1, 1'b0, 4'h1, 1'b0, 64'd0, 64'd0, 64'd20, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 4'h0, 1'b0, 64'd0, 64'd0, 64'd30, 1'b1, 1'b1);
      chk_all("adr", 64'd20, 2'd2, 1'b0, 4'd0, 32'd1, 16'd0);
      drive(1'b1, 1'b0, 4'h1, 1'b0, 64'd0, 64'd0, 64'd77, 1'b0, 1'b0);
      chk_all("adr_hold", 64'd20, 2'd2, 1'b0, 4'd0, 32'd1, 16'd0);
      drive(1'b1, 1'b1, 4'h1, 1'b0, 64'd0, 64'd0, 64'd78, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 4'h8, 1'b0, 64'h90, 64'd0, 64'd79, 1'b0, 1'b0);
      chk_all("adr_stall", 64'd20, 2'd2, 1'b0, 4'd0, 32'd1, 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end expected finish");
      $fatal(1, "timeout");
   end

endmodule
